// File: rtl/transfer_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// tseq_pkg : state encoding, select codes and step-word field offsets
//            (WAIT state exists only with TSEQ_SINGLE_STEP_EN)
// Revision : 1.0
// ============================================================================
package tseq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_DONE   = 3'd4
`ifdef TSEQ_SINGLE_STEP_EN
        , S_WAIT = 3'd5
`endif
    } state_t;

    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] DST_ACC  = 3'd1;
    localparam logic [2:0] DST_BREG = 3'd2;
    localparam logic [2:0] DST_OUT  = 3'd4;
    localparam logic [2:0] SRC_ACC  = 3'd1;
    localparam logic [2:0] SRC_BREG = 3'd2;
    localparam logic [2:0] SRC_IN   = 3'd3;

    // Offsets are relative to HW: the hold field occupies [HW-1:0].
    localparam int LAST_OFS = 7;
    localparam int DST_OFS  = 4;
    localparam int SRC_OFS  = 1;

endpackage
`default_nettype wire

// File: rtl/transfer_sequencer_if.sv
`default_nettype none
// ============================================================================
// transfer_sequencer_if : program-load, start/busy/done and transfer port
//                         (step present only with TSEQ_SINGLE_STEP_EN)
// Revision : 1.0
// ============================================================================
interface transfer_sequencer_if #(
    parameter int AW = 4,
    parameter int HW = 4
);
    logic            prog_we;
    logic [AW-1:0]   prog_addr;
    logic [7+HW:0]   prog_data;
    logic            start;
    logic [AW-1:0]   start_addr;
`ifdef TSEQ_SINGLE_STEP_EN
    logic            step;
`endif
    logic [2:0]      seldst;
    logic [2:0]      selsrc;
    logic            dsten;
    logic            srcen;
    logic            busy;
    logic            done;

    modport master (
`ifdef TSEQ_SINGLE_STEP_EN
        output step,
`endif
        output prog_we, prog_addr, prog_data, start, start_addr,
        input  seldst, selsrc, dsten, srcen, busy, done
    );

    modport slave (
`ifdef TSEQ_SINGLE_STEP_EN
        input  step,
`endif
        input  prog_we, prog_addr, prog_data, start, start_addr,
        output seldst, selsrc, dsten, srcen, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/transfer_sequencer_prog_ram.sv
`default_nettype none
// ============================================================================
// tseq_prog_ram : 2^AW x DW register file, synchronous write, async read
// Revision : 1.0
// ============================================================================
module tseq_prog_ram #(
    parameter int AW = 4,
    parameter int DW = 12
) (
    input  wire logic          clk,
    input  wire logic          we,
    input  wire logic [AW-1:0] waddr,
    input  wire logic [DW-1:0] wdata,
    input  wire logic [AW-1:0] raddr,
    output logic      [DW-1:0] rdata
);
    logic [DW-1:0] r_mem [2**AW];

    // Contents deliberately survive reset so a program can be replayed.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];
endmodule
`default_nettype wire

// File: rtl/transfer_sequencer.sv
`default_nettype none
// ============================================================================
// transfer_sequencer : replays a stored program of register transfers
//                      (optional WAIT/step via TSEQ_SINGLE_STEP_EN)
// Revision : 1.0
// ============================================================================
module transfer_sequencer
    import tseq_pkg::*;
#(
    parameter int AW = 4,
    parameter int HW = 4
) (
    input wire logic               clk,
    input wire logic               rst,
    transfer_sequencer_if.slave    bus
);
    localparam int              DW       = 8 + HW;
    localparam logic [AW-1:0]   c_pc_max = '1;

    state_t          r_state, w_state_nxt;
    logic [AW-1:0]   r_pc, w_pc_nxt;
    logic [HW-1:0]   r_hold, w_hold_nxt;
    logic [DW-1:0]   r_word, w_word_nxt, w_rd_data, w_fetch;
    logic            w_ram_we, w_step_end, w_advance;
    logic [2:0]      r_seldst, r_selsrc, w_seldst, w_selsrc;
    logic            r_dsten, r_srcen, r_busy, r_done;
    logic            w_dsten, w_srcen, w_busy, w_done;
    logic [2:0]      w_dst, w_src;

    assign w_ram_we = (r_state == S_IDLE) && bus.prog_we;

    tseq_prog_ram #(.AW(AW), .DW(DW)) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .waddr (bus.prog_addr),
        .wdata (bus.prog_data),
        .raddr (w_pc_nxt),
        .rdata (w_rd_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_hold_nxt  = r_hold;
        w_step_end  = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_pc_nxt    = bus.start_addr;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP:  w_state_nxt = S_STROBE;
            S_STROBE: begin
                if (r_word[HW-1:0] != '0) begin
                    w_hold_nxt  = r_word[HW-1:0];
                    w_state_nxt = S_HOLD;
                end else begin
                    w_step_end = 1'b1;
                end
            end
            S_HOLD: begin
                if (r_hold == HW'(1)) begin
                    w_step_end = 1'b1;
                end else begin
                    w_hold_nxt = r_hold - 1'b1;
                end
            end
`ifdef TSEQ_SINGLE_STEP_EN
            S_WAIT:   w_advance = bus.step;
`endif
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
`ifdef TSEQ_SINGLE_STEP_EN
        if (w_step_end) begin
            w_state_nxt = S_WAIT;
        end
`else
        w_advance = w_step_end;
`endif
        if (w_advance) begin
            if (r_word[HW+LAST_OFS] || (r_pc == c_pc_max)) begin
                w_state_nxt = S_DONE;
            end else begin
                w_pc_nxt    = r_pc + 1'b1;
                w_state_nxt = S_SETUP;
            end
        end
    end

    // A write and a start in the same IDLE cycle: the run sees the new word.
    assign w_fetch    = (w_ram_we && (bus.prog_addr == w_pc_nxt)) ? bus.prog_data : w_rd_data;
    assign w_word_nxt = (w_state_nxt == S_SETUP) ? w_fetch : r_word;
    assign w_dst      = w_word_nxt[HW+DST_OFS +: 3];
    assign w_src      = w_word_nxt[HW+SRC_OFS +: 3];

    // Outputs are decoded from the next state so every port is a flop.
    always_comb begin
        w_seldst = SEL_NONE;
        w_selsrc = SEL_NONE;
        w_dsten  = 1'b0;
        w_srcen  = 1'b0;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        case (w_state_nxt)
            S_SETUP, S_HOLD
`ifdef TSEQ_SINGLE_STEP_EN
            , S_WAIT
`endif
            : begin
                w_seldst = w_dst;
                w_selsrc = w_src;
                w_busy   = 1'b1;
            end
            S_STROBE: begin
                w_seldst = w_dst;
                w_selsrc = w_src;
                w_dsten  = (w_dst != SEL_NONE);
                w_srcen  = (w_src != SEL_NONE);
                w_busy   = 1'b1;
            end
            S_DONE:  w_done = 1'b1;
            default: w_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_hold   <= '0;
            r_word   <= '0;
            r_seldst <= SEL_NONE;
            r_selsrc <= SEL_NONE;
            r_dsten  <= 1'b0;
            r_srcen  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_hold   <= w_hold_nxt;
            r_word   <= w_word_nxt;
            r_seldst <= w_seldst;
            r_selsrc <= w_selsrc;
            r_dsten  <= w_dsten;
            r_srcen  <= w_srcen;
            r_busy   <= w_busy;
            r_done   <= w_done;
        end
    end

    assign bus.seldst = r_seldst;
    assign bus.selsrc = r_selsrc;
    assign bus.dsten  = r_dsten;
    assign bus.srcen  = r_srcen;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
endmodule
`default_nettype wire

// File: tb/tb_transfer_sequencer.sv
`default_nettype none
// ============================================================================
// tb_transfer_sequencer : directed runs, scoreboard of strobes and done pulses
// Revision : 1.0
// ============================================================================
module tb_transfer_sequencer;
    import tseq_pkg::*;

    localparam int AW = 4;
    localparam int HW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    transfer_sequencer_if #(.AW(AW), .HW(HW)) bus();
    transfer_sequencer #(.AW(AW), .HW(HW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int       cyc;
        logic [2:0] dst;
        logic [2:0] src;
        logic     de;
        logic     se;
        logic     dn;
        int       busy;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    int         checks   = 0;
    int         errors   = 0;
    int         cyc      = 0;
    int         busy_cnt = 0;
    int         done_cnt = 0;
    logic [11:0] mem_m [16];

    function automatic logic [11:0] wd(logic last, logic [2:0] d, logic [2:0] s, logic [3:0] h);
        return {last, d, s, 1'b0, h};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe or done pulse must match the head of the queue.
    always @(negedge clk) begin
        if (!rst) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.dsten || bus.srcen || bus.done) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output cyc=%0d dst=%0d src=%0d de=%b se=%b done=%b",
                             cyc, bus.seldst, bus.selsrc, bus.dsten, bus.srcen, bus.done);
                end else begin
                    e = q.pop_front();
                    if (cyc != e.cyc || bus.seldst !== e.dst || bus.selsrc !== e.src ||
                        bus.dsten !== e.de || bus.srcen !== e.se || bus.done !== e.dn ||
                        (e.dn && (bus.busy !== 1'b0 || busy_cnt != e.busy))) begin
                        errors++;
                        $display("FAIL output_event got cyc=%0d dst=%0d src=%0d de=%b se=%b done=%b busy=%b busycyc=%0d required cyc=%0d dst=%0d src=%0d de=%b se=%b done=%b busycyc=%0d",
                                 cyc, bus.seldst, bus.selsrc, bus.dsten, bus.srcen, bus.done, bus.busy,
                                 busy_cnt, e.cyc, e.dst, e.src, e.de, e.se, e.dn, e.busy);
                    end
                end
                if (bus.done) begin
                    done_cnt++;
                    busy_cnt = 0;
                end
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write(int a, logic [11:0] d);
        bus.prog_we   = 1'b1;
        bus.prog_addr = AW'(a);
        bus.prog_data = d;
        mem_m[a]      = d;
        tick();
        bus.prog_we   = 1'b0;
    endtask

    // Behavioural model of a run starting at cycle t0.
    task automatic expect_run(int sa, int t0);
        int c  = t0 + 1;
        int pc = sa;
        logic [11:0] w;
        forever begin
            w = mem_m[pc];
            if (w[10:8] != 0 || w[7:5] != 0)
                q.push_back('{c + 1, w[10:8], w[7:5], w[10:8] != 0, w[7:5] != 0, 1'b0, 0});
            c += 2 + int'(w[3:0]);
            if (w[11] || pc == 15) break;
            pc++;
        end
        q.push_back('{c, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, c - t0 - 1});
    endtask

    task automatic launch(int sa);
        expect_run(sa, cyc);
        bus.start      = 1'b1;
        bus.start_addr = AW'(sa);
        tick();
        bus.start      = 1'b0;
    endtask

    task automatic wait_done(int budget);
        int d0 = done_cnt;
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL done_timeout got no done within %0d cycles, required a done pulse", budget);
        end
    endtask

    task automatic check_quiet(string name);
        checks++;
        if ({bus.seldst, bus.selsrc, bus.dsten, bus.srcen, bus.busy, bus.done} !== 10'd0) begin
            errors++;
            $display("FAIL %s got sel=%0d/%0d en=%b%b busy=%b done=%b required all 0",
                     name, bus.seldst, bus.selsrc, bus.dsten, bus.srcen, bus.busy, bus.done);
        end
    endtask

    initial begin
        int t0;
        bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
        bus.start = 1'b0;   bus.start_addr = '0;
        tick(3);
        check_quiet("reset_outputs");
        rst = 1'b1;
        tick(2);

        // Basic run, hand-computed timeline.
        write(0, wd(1'b0, DST_ACC,  SRC_IN,  4'd10));
        write(1, wd(1'b0, DST_OUT,  SRC_ACC, 4'd10));
        write(2, wd(1'b1, DST_BREG, SRC_IN,  4'd0));
        t0 = cyc;
        q.push_back('{t0 + 2,  DST_ACC,  SRC_IN,  1'b1, 1'b1, 1'b0, 0});
        q.push_back('{t0 + 14, DST_OUT,  SRC_ACC, 1'b1, 1'b1, 1'b0, 0});
        q.push_back('{t0 + 26, DST_BREG, SRC_IN,  1'b1, 1'b1, 1'b0, 0});
        q.push_back('{t0 + 27, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 26});
        bus.start = 1'b1; bus.start_addr = '0;
        tick();
        bus.start = 1'b0;
        wait_done(60);

        // Delay step followed by a single-sided transfer; restart right after done.
        write(3, wd(1'b0, SEL_NONE, SEL_NONE, 4'd3));
        write(4, wd(1'b1, DST_ACC,  SRC_BREG, 4'd0));
        launch(3);
        wait_done(30);
        write(6, wd(1'b1, DST_OUT, SEL_NONE, 4'd2));
        launch(6);
        wait_done(30);

        // Start and write during a run are ignored.
        launch(0);
        tick(3);
        bus.prog_we = 1'b1; bus.prog_addr = 4'd2; bus.prog_data = wd(1'b1, 3'd0, 3'd0, 4'd0);
        bus.start = 1'b1;   bus.start_addr = 4'd5;
        tick();
        bus.prog_we = 1'b0; bus.start = 1'b0;
        wait_done(60);

        // Start during DONE is ignored.
        launch(4);
        tick(2);
        bus.start = 1'b1; bus.start_addr = 4'd4;
        tick();
        bus.start = 1'b0;
        tick(4);
        check_quiet("start_in_done_ignored");

        // Write and start in the same IDLE cycle: the run uses the new word.
        mem_m[5] = wd(1'b1, DST_BREG, SRC_ACC, 4'd1);
        expect_run(5, cyc);
        bus.prog_we = 1'b1; bus.prog_addr = 4'd5; bus.prog_data = mem_m[5];
        bus.start = 1'b1;   bus.start_addr = 4'd5;
        tick();
        bus.prog_we = 1'b0; bus.start = 1'b0;
        wait_done(30);

        // No last bit: the run ends at the top address without wrapping.
        write(14, wd(1'b0, DST_ACC, SRC_IN,  4'd1));
        write(15, wd(1'b0, DST_OUT, SRC_ACC, 4'd0));
        launch(14);
        wait_done(30);

        // Reset in HOLD aborts at once; rerun replays the unchanged program.
        launch(0);
        tick(4);
        rst = 1'b0;
        #1;
        check_quiet("reset_mid_run");
        q.delete();
        tick(2);
        rst = 1'b1;
        tick();
        launch(0);
        wait_done(60);

        tick(3);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_events got %0d outstanding, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
